seg_scan_drv: RTL

Time-multiplexed scan driver for the four-digit segment display. Takes the four parallel 8-bit segment patterns produced by the lab display generator (lout0..lout3) and drives them onto one shared 8-bit segment bus with four one-hot digit selects. The four patterns are snapshotted once per frame so a digit can never show a mix of old and new data. Sits between the display generator and the board pins.

---
 rtl/seg_scan_pkg.sv | 31 +++
 rtl/seg_scan_timer.sv | 29 ++
 rtl/seg_scan_drv.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types and constants for the four-digit scan driver.
// State encoding, one-hot anode constants, blank segment pattern and the
// digit-index to anode decoder.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [3:0] AN_D0   = 4'b0001;
  localparam logic [3:0] AN_D1   = 4'b0010;
  localparam logic [3:0] AN_D2   = 4'b0100;
  localparam logic [3:0] AN_D3   = 4'b1000;
  localparam logic [7:0] SEG_OFF = 8'h00;

  // Map a digit index to its one-hot anode select.
  function automatic logic [3:0] an_sel(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = AN_D0;
      2'd1:    an = AN_D1;
      2'd2:    an = AN_D2;
      2'd3:    an = AN_D3;
      default: an = 4'b0000;
    endcase
    return an;
  endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// seg_scan_timer: dwell/blank cycle counter for the scan driver.
// Counts up from zero while not cleared; term is high while the count equals
// the terminal value tc (terminal count minus one, supplied by the FSM).
module seg_scan_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [CW-1:0] tc,
  output logic          term
);

  logic [CW-1:0] cnt_r;

  // Cycle counter, restarted by the FSM on every state or digit change.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

  assign term = (cnt_r == tc);

endmodule

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: time-multiplexed scan driver for a four-digit segment display.
// Snapshots lin0..lin3 at scan start and at every 3->0 wrap, then shows each
// digit for DWELL cycles on a shared segment bus with one-hot anode selects.
// Optional macro SCAN_BLANK_EN inserts BLANK dead cycles after every digit.
module seg_scan_drv
  import seg_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int BLANK = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] lin0,
  input  logic [7:0] lin1,
  input  logic [7:0] lin2,
  input  logic [7:0] lin3,
  output logic [7:0] seg_out,
  output logic [3:0] an_out,
  output logic [1:0] digit_idx,
  output logic       frame_done
);

  localparam int MAXV = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CW   = $clog2(MAXV) + 1;
  localparam logic [CW-1:0] DWELL_TC = CW'(DWELL - 1);
`ifdef SCAN_BLANK_EN
  localparam logic [CW-1:0] BLANK_TC = CW'(BLANK - 1);
`endif

  state_t          state_r;
  state_t          state_s;
  logic [1:0]      idx_r;
  logic [1:0]      idx_s;
  logic [3:0][7:0] snap_r;
  logic            load_s;
  logic            wrap_r;
  logic            wrap_s;
  logic            clr_s;
  logic            term_s;
  logic [CW-1:0]   tc_s;

`ifdef SCAN_BLANK_EN
  assign tc_s = (state_r == ST_BLANK) ? BLANK_TC : DWELL_TC;
`else
  assign tc_s = DWELL_TC;
`endif

  seg_scan_timer #(.CW(CW)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tc   (tc_s),
    .term (term_s)
  );

  // Next-state logic: digit advance, snapshot reload and wrap detection.
  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    load_s  = 1'b0;
    wrap_s  = 1'b0;
    clr_s   = 1'b0;
    if (!enable) begin
      state_s = ST_IDLE;
      idx_s   = 2'd0;
      clr_s   = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_SHOW;
          idx_s   = 2'd0;
          load_s  = 1'b1;
          clr_s   = 1'b1;
        end
        ST_SHOW: begin
          if (term_s) begin
            clr_s = 1'b1;
`ifdef SCAN_BLANK_EN
            state_s = ST_BLANK;
`else
            state_s = ST_SHOW;
            idx_s   = idx_r + 2'd1;
            if (idx_r == 2'd3) begin
              load_s = 1'b1;
              wrap_s = 1'b1;
            end else begin
              load_s = 1'b0;
            end
`endif
          end else begin
            clr_s = 1'b0;
          end
        end
`ifdef SCAN_BLANK_EN
        ST_BLANK: begin
          if (term_s) begin
            clr_s   = 1'b1;
            state_s = ST_SHOW;
            idx_s   = idx_r + 2'd1;
            if (idx_r == 2'd3) begin
              load_s = 1'b1;
              wrap_s = 1'b1;
            end else begin
              load_s = 1'b0;
            end
          end else begin
            clr_s = 1'b0;
          end
        end
`endif
        default: begin
          state_s = ST_IDLE;
          idx_s   = 2'd0;
          clr_s   = 1'b1;
        end
      endcase
    end
  end

  // State, digit index, wrap flag and frame snapshot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 2'd0;
      wrap_r  <= 1'b0;
      snap_r  <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      wrap_r  <= wrap_s;
      if (load_s) begin
        snap_r <= {lin3, lin2, lin1, lin0};
      end else begin
        snap_r <= snap_r;
      end
    end
  end

  // Registered outputs decoded from the state; a low enable blanks them at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out    <= SEG_OFF;
      an_out     <= 4'b0000;
      digit_idx  <= 2'd0;
      frame_done <= 1'b0;
    end else if (enable && (state_r == ST_SHOW)) begin
      seg_out    <= snap_r[idx_r];
      an_out     <= an_sel(idx_r);
      digit_idx  <= idx_r;
      frame_done <= wrap_r;
    end
`ifdef SCAN_BLANK_EN
    else if (enable && (state_r == ST_BLANK)) begin
      seg_out    <= SEG_OFF;
      an_out     <= 4'b0000;
      digit_idx  <= idx_r;
      frame_done <= 1'b0;
    end
`endif
    else begin
      seg_out    <= SEG_OFF;
      an_out     <= 4'b0000;
      digit_idx  <= 2'd0;
      frame_done <= 1'b0;
    end
  end

endmodule
